mc_rr_read_scheduler: RTL and testbench

- Shares one synchronous-read memory port among ARBITER_SIZE load requesters.
- Uses round-robin grants, tracks each in-flight read through a fixed-latency return pipe, and holds returned data in per-requester output registers until that requester accepts it.
- Sits between the load ports and the BRAM read interface inside a memory controller.
- Its allRequestsDone output feeds the memory controller's end-of-kernel control.

---
 rtl/mc_rr_read_scheduler_pkg.sv | 16 +
 rtl/mc_rr_grant.sv | 30 +++
 rtl/mc_rr_read_scheduler.sv | 120 ++++++++++++
 tb/tb_mc_rr_read_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_rr_read_scheduler_pkg.sv
// Shared memory-controller types: requester index sizing and the return-pipe entry.
package mc_rr_read_scheduler_pkg;

    // Widest requester index a pipe entry can carry (up to 256 requesters).
    localparam int unsigned IDX_MAX_W = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 v;
        logic [IDX_MAX_W-1:0] idx;
    } pipe_entry_t;

endpackage

// File: rtl/mc_rr_grant.sv
// Rotating-priority picker: first requester after ptr_i (mod N) wins, one-hot grant.
module mc_rr_grant #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_rr_read_scheduler.sv
// Round-robin read scheduler: shares one fixed-latency memory read port among
// ARBITER_SIZE load requesters and holds each returned word until it is accepted.
module mc_rr_read_scheduler
    import mc_rr_read_scheduler_pkg::*;
#(
    parameter int unsigned ARBITER_SIZE = 2,
    parameter int unsigned ADDR_TYPE    = 32,
    parameter int unsigned DATA_TYPE    = 32,
    parameter int unsigned MEM_LATENCY  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ARBITER_SIZE-1:0]           pValid,
    output logic [ARBITER_SIZE-1:0]           ready,
    input  logic [ARBITER_SIZE*ADDR_TYPE-1:0] address_in,
    output logic [ARBITER_SIZE-1:0]           valid,
    input  logic [ARBITER_SIZE-1:0]           nReady,
    output logic [ARBITER_SIZE*DATA_TYPE-1:0] data_out,
    output logic                              read_enable,
    output logic [ADDR_TYPE-1:0]              read_address,
    input  logic [DATA_TYPE-1:0]              data_from_memory,
    output logic                              allRequestsDone
);

    localparam int unsigned N     = ARBITER_SIZE;
    localparam int unsigned IDX_W = idx_width(ARBITER_SIZE);
    localparam int unsigned LAT   = MEM_LATENCY;

    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [N-1:0]                    inflight_q, inflight_d;
    logic [N-1:0]                    valid_q, valid_d;
    logic [N-1:0][DATA_TYPE-1:0]     out_q, out_d;
    pipe_entry_t [LAT-1:0]           pipe_q, pipe_d;

    logic [N-1:0][ADDR_TYPE-1:0]     addr_c;
    logic [N-1:0]                    elig_c;
    logic [N-1:0]                    grant_c;
    logic [IDX_W-1:0]                grant_idx_c;
    logic                            grant_any_c;
    pipe_entry_t                     ret_c;

    assign addr_c = address_in;

    // A held result or outstanding read blocks a new grant; nothing is granted in reset.
    assign elig_c = pValid & ~inflight_q & ~valid_q & {N{rst}};

    mc_rr_grant #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_grant (
        .req_i   (elig_c),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_c),
        .idx_o   (grant_idx_c),
        .any_o   (grant_any_c)
    );

    assign ready       = grant_c;
    assign read_enable = grant_any_c;

    always_comb begin
        read_address = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_c[i]) begin
                read_address = read_address | addr_c[i];
            end
        end
    end

    // Last pipe stage lines up with data_from_memory for its request.
    assign ret_c = pipe_q[LAT-1];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        inflight_d = inflight_q;
        valid_d    = valid_q & ~nReady;
        out_d      = out_q;
        pipe_d     = pipe_q;

        pipe_d[0] = '{v: grant_any_c, idx: IDX_MAX_W'(grant_idx_c)};
        for (int unsigned i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (grant_any_c) begin
            rr_ptr_d   = grant_idx_c;
            inflight_d = inflight_d | grant_c;
        end

        // Capture cannot collide with a drain: a requester with a read in flight holds no data.
        for (int unsigned i = 0; i < N; i++) begin
            if (ret_c.v && (ret_c.idx == IDX_MAX_W'(i))) begin
                out_d[i]      = data_from_memory;
                valid_d[i]    = 1'b1;
                inflight_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= IDX_W'(N - 1);
            inflight_q <= '0;
            valid_q    <= '0;
            out_q      <= '0;
            pipe_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            pipe_q     <= pipe_d;
        end
    end

    assign valid           = valid_q;
    assign data_out        = out_q;
    assign allRequestsDone = ~|inflight_q & ~|valid_q;

endmodule

// File: tb/tb_mc_rr_read_scheduler.sv
// Directed bench for mc_rr_read_scheduler: a vector table on a 2-requester, latency-2
// instance plus hand sequences for reset, back-pressure and a 3-deep pipeline.
module tb_mc_rr_read_scheduler;

    typedef struct {
        logic [1:0]  pv;
        logic [1:0]  nr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] dm;
        logic [1:0]  e_rdy;
        logic [31:0] e_ra;
        logic [1:0]  e_val;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_done;
    } vec_t;

    localparam int unsigned NVEC = 19;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  pv, nr, rdy, vld;
    logic [63:0] addr, dout;
    logic        re, done, use_model;
    logic [31:0] ra, dmem, tbl_dm;
    logic [31:0] m2 [2];

    logic [2:0]  pv3, nr3, rdy3, vld3;
    logic [95:0] addr3, dout3;
    logic        re3, done3;
    logic [31:0] ra3, dmem3;
    logic [31:0] m3 [3];

    vec_t        tbl [NVEC];
    logic [2:0]  e_r3 [7];
    logic [2:0]  e_v3 [7];

    int n_pass = 0;
    int n_total = 0;
    int g0, g1, v0, onehot_err, derr, stale_err;

    always #5 clk = ~clk;

    // Memory models: return addr ^ 0xA5A50000 exactly MEM_LATENCY cycles after the strobe cycle.
    always @(posedge clk) begin
        m2[0] <= ra;
        m2[1] <= m2[0];
        m3[0] <= ra3;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end

    assign dmem  = use_model ? (m2[1] ^ 32'hA5A5_0000) : tbl_dm;
    assign dmem3 = m3[2] ^ 32'hA5A5_0000;

    mc_rr_read_scheduler #(
        .ARBITER_SIZE (2),
        .ADDR_TYPE    (32),
        .DATA_TYPE    (32),
        .MEM_LATENCY  (2)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .pValid           (pv),
        .ready            (rdy),
        .address_in       (addr),
        .valid            (vld),
        .nReady           (nr),
        .data_out         (dout),
        .read_enable      (re),
        .read_address     (ra),
        .data_from_memory (dmem),
        .allRequestsDone  (done)
    );

    mc_rr_read_scheduler #(
        .ARBITER_SIZE (3),
        .ADDR_TYPE    (32),
        .DATA_TYPE    (32),
        .MEM_LATENCY  (3)
    ) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .pValid           (pv3),
        .ready            (rdy3),
        .address_in       (addr3),
        .valid            (vld3),
        .nReady           (nr3),
        .data_out         (dout3),
        .read_enable      (re3),
        .read_address     (ra3),
        .data_from_memory (dmem3),
        .allRequestsDone  (done3)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    task automatic wait_done3(input string nm);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done3) break;
        end
        chk(nm, 64'(done3), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          pv     nr     a0      a1      dm       rdy    ra      val    d0      d1      done
        tbl[0]  = '{2'b01, 2'b00, 32'h10, 32'h20, 32'h00, 2'b01, 32'h10, 2'b00, 32'h00, 32'h00, 1'b1};
        tbl[1]  = '{2'b00, 2'b00, 32'h00, 32'h00, 32'h00, 2'b00, 32'h00, 2'b00, 32'h00, 32'h00, 1'b0};
        tbl[2]  = '{2'b00, 2'b00, 32'h00, 32'h00, 32'hAB, 2'b00, 32'h00, 2'b00, 32'h00, 32'h00, 1'b0};
        tbl[3]  = '{2'b01, 2'b00, 32'h10, 32'h00, 32'h55, 2'b00, 32'h00, 2'b01, 32'hAB, 32'h00, 1'b0};
        tbl[4]  = '{2'b01, 2'b01, 32'h10, 32'h00, 32'h00, 2'b00, 32'h00, 2'b01, 32'hAB, 32'h00, 1'b0};
        tbl[5]  = '{2'b01, 2'b00, 32'h14, 32'h00, 32'h00, 2'b01, 32'h14, 2'b00, 32'hAB, 32'h00, 1'b1};
        tbl[6]  = '{2'b10, 2'b00, 32'h00, 32'h24, 32'h00, 2'b10, 32'h24, 2'b00, 32'hAB, 32'h00, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 32'h00, 32'h00, 32'hC0, 2'b00, 32'h00, 2'b00, 32'hAB, 32'h00, 1'b0};
        tbl[8]  = '{2'b00, 2'b01, 32'h00, 32'h00, 32'hD1, 2'b00, 32'h00, 2'b01, 32'hC0, 32'h00, 1'b0};
        tbl[9]  = '{2'b00, 2'b10, 32'h00, 32'h00, 32'h00, 2'b00, 32'h00, 2'b10, 32'hC0, 32'hD1, 1'b0};
        tbl[10] = '{2'b11, 2'b00, 32'h30, 32'h34, 32'h00, 2'b01, 32'h30, 2'b00, 32'hC0, 32'hD1, 1'b1};
        tbl[11] = '{2'b11, 2'b00, 32'h30, 32'h34, 32'h00, 2'b10, 32'h34, 2'b00, 32'hC0, 32'hD1, 1'b0};
        tbl[12] = '{2'b11, 2'b00, 32'h30, 32'h34, 32'hE0, 2'b00, 32'h00, 2'b00, 32'hC0, 32'hD1, 1'b0};
        tbl[13] = '{2'b11, 2'b11, 32'h30, 32'h34, 32'hE1, 2'b00, 32'h00, 2'b01, 32'hE0, 32'hD1, 1'b0};
        tbl[14] = '{2'b11, 2'b11, 32'h30, 32'h34, 32'h00, 2'b01, 32'h30, 2'b10, 32'hE0, 32'hE1, 1'b0};
        tbl[15] = '{2'b00, 2'b11, 32'h00, 32'h00, 32'h00, 2'b00, 32'h00, 2'b00, 32'hE0, 32'hE1, 1'b0};
        tbl[16] = '{2'b00, 2'b11, 32'h00, 32'h00, 32'hF0, 2'b00, 32'h00, 2'b00, 32'hE0, 32'hE1, 1'b0};
        tbl[17] = '{2'b00, 2'b11, 32'h00, 32'h00, 32'h00, 2'b00, 32'h00, 2'b01, 32'hF0, 32'hE1, 1'b0};
        tbl[18] = '{2'b00, 2'b00, 32'h00, 32'h00, 32'h00, 2'b00, 32'h00, 2'b00, 32'hF0, 32'hE1, 1'b1};

        e_r3 = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b001, 3'b010};
        e_v3 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100};

        rst = 1'b0; use_model = 1'b0; tbl_dm = '0;
        pv = 2'b11; nr = 2'b00; addr = {32'h20, 32'h10};
        pv3 = 3'b000; nr3 = 3'b000; addr3 = '0;
        #2;
        chk("reset_ready", 64'(rdy), 64'd0);
        chk("reset_read_enable", 64'(re), 64'd0);
        chk("reset_read_address", 64'(ra), 64'd0);
        chk("reset_valid", 64'(vld), 64'd0);
        chk("reset_done", 64'(done), 64'd1);
        chk("reset_done3", 64'(done3), 64'd1);

        @(negedge clk);
        rst = 1'b1;
        pv  = 2'b00;

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            pv     = tbl[i].pv;
            nr     = tbl[i].nr;
            addr   = {tbl[i].a1, tbl[i].a0};
            tbl_dm = tbl[i].dm;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_read_enable", i), 64'(re), 64'(|tbl[i].e_rdy));
            chk($sformatf("v%0d_read_address", i), 64'(ra), 64'(tbl[i].e_ra));
            chk($sformatf("v%0d_valid", i), 64'(vld), 64'(tbl[i].e_val));
            chk($sformatf("v%0d_data0", i), 64'(dout[31:0]), 64'(tbl[i].e_d0));
            chk($sformatf("v%0d_data1", i), 64'(dout[63:32]), 64'(tbl[i].e_d1));
            chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].e_done));
        end

        // Reset with a read in flight: outputs clear at once, stale return is dropped.
        use_model = 1'b1;
        @(negedge clk);
        pv = 2'b10; nr = 2'b00; addr = {32'h40, 32'h44};
        #1;
        chk("rp_grant1", 64'(rdy), 64'b10);
        @(negedge clk);
        pv = 2'b11; rst = 1'b0;
        #1;
        chk("rp_in_reset_ready", 64'(rdy), 64'd0);
        chk("rp_in_reset_read_enable", 64'(re), 64'd0);
        chk("rp_in_reset_valid", 64'(vld), 64'd0);
        chk("rp_in_reset_done", 64'(done), 64'd1);
        @(negedge clk);
        rst = 1'b1; pv = 2'b00;
        #1;
        chk("rp_after_release_done", 64'(done), 64'd1);
        @(negedge clk);
        pv = 2'b11;
        #1;
        chk("rp_stale_not_captured", 64'(vld), 64'd0);
        chk("rp_ptr_restart_at_0", 64'(rdy), 64'b01);
        @(negedge clk);
        pv = 2'b00; nr = 2'b11;
        #1;
        wait_done("rp_drain_done");

        // Requester 0 stalls its consumer; requester 1 keeps being served.
        g0 = 0; g1 = 0; v0 = 0; onehot_err = 0; derr = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            pv = 2'b11; nr = 2'b10; addr = {32'h200, 32'h100};
            #1;
            if (rdy[0]) g0++;
            if (rdy[1]) g1++;
            if (rdy == 2'b11) onehot_err++;
            if (vld[0]) begin
                v0++;
                if (dout[31:0] !== f(32'h100)) derr++;
            end
            if (vld[1] && (dout[63:32] !== f(32'h200))) derr++;
        end
        chk("bp_grants_req0", 64'(g0), 64'd1);
        chk("bp_grants_req1", 64'(g1), 64'd6);
        chk("bp_valid0_held_cycles", 64'(v0), 64'd20);
        chk("bp_onehot_violations", 64'(onehot_err), 64'd0);
        chk("bp_data_errors", 64'(derr), 64'd0);
        @(negedge clk);
        pv = 2'b00; nr = 2'b11;
        #1;
        wait_done("bp_drain_done");
        stale_err = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (!done || vld != 2'b00) stale_err++;
        end
        chk("bp_idle_stays_done", 64'(stale_err), 64'd0);

        // Three requesters, latency 3: back-to-back grants fill the pipe.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            pv3 = 3'b111; nr3 = 3'b111;
            addr3 = {32'h3000, 32'h2000, 32'h1000};
            #1;
            chk($sformatf("p3_c%0d_ready", c), 64'(rdy3), 64'(e_r3[c]));
            chk($sformatf("p3_c%0d_valid", c), 64'(vld3), 64'(e_v3[c]));
            if (c < 3) begin
                chk($sformatf("p3_c%0d_read_address", c), 64'(ra3), 64'(32'h1000 * (c + 1)));
            end
            if (c == 3) begin
                chk("p3_done_low_inflight", 64'(done3), 64'd0);
            end
            for (int j = 0; j < 3; j++) begin
                if (e_v3[c][j]) begin
                    chk($sformatf("p3_c%0d_data%0d", c, j), 64'(dout3[j*32 +: 32]),
                        64'(f(32'h1000 * (j + 1))));
                end
            end
        end
        @(negedge clk);
        pv3 = 3'b000;
        #1;
        wait_done3("p3_drain_done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
